// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package instr_fetch_pkg;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_DROP
  } fetch_state_t;

  localparam logic [DATA_W-1:0] NO_OP  = 32'hF000_0000;
  localparam logic [DATA_W-1:0] PC_INC = 32'd4;
endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port: one-cycle request strobe, one-cycle data-valid strobe.
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic              imem_req;
  logic [DATA_W-1:0] imem_addr;
  logic              imem_valid;
  logic [DATA_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_valid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_valid, imem_rdata);
endinterface

// File: rtl/instr_fetch_buf.sv
// Small synchronous FIFO holding {pc, instruction} pairs; head is read combinationally.
module fetch_buf #(
  parameter  int DEPTH   = 2,
  parameter  int ENTRY_W = 64,
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] head,
  output logic [CNT_W-1:0]   count
);
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: single-outstanding memory request FSM feeding a small prefetch buffer.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter int                BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_if.master      imem,
  input  logic               data_hazard,
  input  logic               PC_hazard,
  input  logic [DATA_W-1:0]  branch_target,
  output logic [DATA_W-1:0]  instruction_in,
  output logic [DATA_W-1:0]  PC_in,
  output logic               fetch_valid
);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_t        state_q, state_d;
  logic [DATA_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic                push, pop, req;
  logic [CNT_W-1:0]    count;
  logic [2*DATA_W-1:0] head;
  logic                empty;

  fetch_buf #(.DEPTH(BUF_DEPTH), .ENTRY_W(2*DATA_W)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (PC_hazard),
    .din   ({fetch_pc_q, imem.imem_rdata}),
    .head  (head),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_REQ;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req        = 1'b0;
    push       = 1'b0;
    case (state_q)
      ST_REQ: begin
        if (PC_hazard) begin
          fetch_pc_d = branch_target;
        end else if (count < CNT_W'(BUF_DEPTH)) begin
          req     = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (PC_hazard) begin
          fetch_pc_d = branch_target;
          state_d    = imem.imem_valid ? ST_REQ : ST_DROP;
        end else if (imem.imem_valid) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + PC_INC;
          state_d    = ST_REQ;
        end
      end
      ST_DROP: begin
        if (PC_hazard) fetch_pc_d = branch_target;
        // The stale response retires the only outstanding request, even if a new redirect coincides.
        if (imem.imem_valid) state_d = ST_REQ;
      end
      default: state_d = ST_REQ;
    endcase
  end

  assign empty          = (count == '0);
  assign pop            = !empty && !data_hazard && !PC_hazard;
  // The REQ state is live during reset, so the strobe is held off explicitly.
  assign imem.imem_req  = req && rst_n;
  assign imem.imem_addr = fetch_pc_q;

  assign fetch_valid    = !empty;
  assign instruction_in = empty ? NO_OP : head[DATA_W-1:0];
  assign PC_in          = empty ? fetch_pc_q : head[2*DATA_W-1:DATA_W];
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a latency-programmable memory model and an output scoreboard.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data_hazard, PC_hazard;
  logic [31:0] branch_target;
  logic [31:0] instruction_in, PC_in;
  logic        fetch_valid;

  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (bus),
    .data_hazard    (data_hazard),
    .PC_hazard      (PC_hazard),
    .branch_target  (branch_target),
    .instruction_in (instruction_in),
    .PC_in          (PC_in),
    .fetch_valid    (fetch_valid)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [63:0] sb[$];
  logic [31:0] addr_log[$];
  logic [31:0] pop_log[$];
  int          lat = 1;
  int          cnt = 0;
  logic        pend = 1'b0, stale = 1'b0, inject_late = 1'b0, delivered;
  logic [31:0] paddr = '0;
  logic [31:0] exp_pc = RST_PC;
  logic        exp_req, last_req, last_fv;
  logic [31:0] last_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory response, check outputs against the model, advance.
  task automatic cyc();
    bus.imem_valid = 1'b0;
    bus.imem_rdata = '0;
    delivered      = 1'b0;
    if (inject_late) begin
      bus.imem_valid = 1'b1;
      bus.imem_rdata = 32'hDEAD_BEEF;
      inject_late    = 1'b0;
    end else if (pend) begin
      if (cnt <= 1) begin
        bus.imem_valid = 1'b1;
        bus.imem_rdata = mem_word(paddr);
        pend           = 1'b0;
        delivered      = 1'b1;
      end else cnt--;
    end
    #1;
    last_req = bus.imem_req;
    last_fv  = fetch_valid;
    last_pc  = PC_in;
    chk("fetch_valid", fetch_valid, sb.size() != 0);
    if (sb.size() != 0) begin
      chk("head_pc", PC_in, sb[0][63:32]);
      chk("head_instr", instruction_in, sb[0][31:0]);
    end else begin
      chk("empty_instr", instruction_in, NO_OP);
      chk("empty_pc", PC_in, exp_pc);
    end
    exp_req = rst_n && !PC_hazard && !pend && !delivered && (sb.size() < 2);
    chk("imem_req", bus.imem_req, exp_req);
    if (bus.imem_req === 1'b1) begin
      if (exp_req) chk("imem_addr", bus.imem_addr, exp_pc);
      addr_log.push_back(bus.imem_addr);
      pend  = 1'b1;
      cnt   = lat;
      paddr = bus.imem_addr;
      stale = 1'b0;
    end
    if (rst_n) begin
      if (PC_hazard) begin
        sb.delete();
        exp_pc = branch_target;
        if (pend) stale = 1'b1;
      end else if (sb.size() != 0 && !data_hazard) begin
        pop_log.push_back(sb[0][63:32]);
        void'(sb.pop_front());
      end
      if (delivered && !stale && !PC_hazard) begin
        sb.push_back({paddr, mem_word(paddr)});
        exp_pc = paddr + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset(input int n);
    rst_n = 1'b0;
    #1;
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_fv", fetch_valid, 1'b0);
    chk("rst_instr", instruction_in, NO_OP);
    chk("rst_pc", PC_in, RST_PC);
    sb.delete();
    pend   = 1'b0;
    stale  = 1'b0;
    exp_pc = RST_PC;
    repeat (n) cyc();
    rst_n = 1'b1;
    addr_log.delete();
    pop_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; data_hazard = 1'b0; PC_hazard = 1'b0; branch_target = '0;
    bus.imem_valid = 1'b0; bus.imem_rdata = '0;
    @(posedge clk);
    #1;

    // Latency 1 from reset: address stream and first valid output.
    lat = 1;
    hold_reset(2);
    cyc(); chk("t1_fv_c0", last_fv, 1'b0); chk("t1_req_c0", last_req, 1'b1);
    cyc(); chk("t1_fv_c1", last_fv, 1'b0);
    cyc(); chk("t1_fv_c2", last_fv, 1'b1); chk("t1_pc_c2", last_pc, 32'h0);
    repeat (4) cyc();
    chk("t1_naddr", addr_log.size() >= 3, 1'b1);
    if (addr_log.size() >= 3) begin
      chk("t1_a0", addr_log[0], 32'h0);
      chk("t1_a1", addr_log[1], 32'h4);
      chk("t1_a2", addr_log[2], 32'h8);
    end

    // Downstream stall fills the buffer; release drains in order.
    data_hazard = 1'b1;
    hold_reset(1);
    repeat (2) cyc();
    for (int i = 2; i < 6; i++) begin
      cyc();
      chk("t2_pc_held", last_pc, 32'h0);
    end
    chk("t2_req_full", last_req, 1'b0);
    chk("t2_nreq", addr_log.size(), 2);
    data_hazard = 1'b0;
    repeat (8) cyc();
    chk("t2_npop", pop_log.size() >= 3, 1'b1);
    if (pop_log.size() >= 3) begin
      chk("t2_p0", pop_log[0], 32'h0);
      chk("t2_p1", pop_log[1], 32'h4);
      chk("t2_p2", pop_log[2], 32'h8);
    end

    // Redirect while waiting (latency 3): stale response dropped.
    lat = 3;
    hold_reset(1);
    cyc();
    PC_hazard = 1'b1; branch_target = 32'h100;
    cyc();
    PC_hazard = 1'b0;
    repeat (10) cyc();
    chk("t3_nreq", addr_log.size() >= 2, 1'b1);
    chk("t3_npop", pop_log.size() >= 1, 1'b1);
    if (addr_log.size() >= 2) chk("t3_a1", addr_log[1], 32'h100);
    if (pop_log.size() >= 1) chk("t3_p0", pop_log[0], 32'h100);

    // Redirect coinciding with the response.
    lat = 2;
    hold_reset(1);
    repeat (2) cyc();
    PC_hazard = 1'b1; branch_target = 32'h200;
    cyc();
    PC_hazard = 1'b0;
    repeat (8) cyc();
    chk("t4_nreq", addr_log.size() >= 2, 1'b1);
    chk("t4_npop", pop_log.size() >= 1, 1'b1);
    if (addr_log.size() >= 2) chk("t4_a1", addr_log[1], 32'h200);
    if (pop_log.size() >= 1) chk("t4_p0", pop_log[0], 32'h200);

    // Redirect in REQ to the top of the address space: request suppressed, then wrap.
    lat = 1;
    hold_reset(1);
    PC_hazard = 1'b1; branch_target = 32'hFFFF_FFFC;
    cyc();
    chk("t5_req_suppressed", last_req, 1'b0);
    PC_hazard = 1'b0;
    repeat (6) cyc();
    chk("t5_nreq", addr_log.size() >= 2, 1'b1);
    chk("t5_npop", pop_log.size() >= 2, 1'b1);
    if (addr_log.size() >= 2) begin
      chk("t5_a0", addr_log[0], 32'hFFFF_FFFC);
      chk("t5_a1", addr_log[1], 32'h0);
    end
    if (pop_log.size() >= 2) begin
      chk("t5_p0", pop_log[0], 32'hFFFF_FFFC);
      chk("t5_p1", pop_log[1], 32'h0);
    end

    // Reset pulsed mid-WAIT with a non-empty buffer; late response ignored.
    lat = 1;
    data_hazard = 1'b1;
    hold_reset(1);
    repeat (2) cyc();
    lat = 3;
    cyc();
    chk("t6_fv_before", fetch_valid, 1'b1);
    hold_reset(1);
    data_hazard = 1'b0;
    inject_late = 1'b1;
    cyc();
    repeat (6) cyc();
    chk("t6_nreq", addr_log.size() >= 2, 1'b1);
    chk("t6_npop", pop_log.size() >= 1, 1'b1);
    if (addr_log.size() >= 2) begin
      chk("t6_a0", addr_log[0], RST_PC);
      chk("t6_a1", addr_log[1], RST_PC + 32'd4);
    end
    if (pop_log.size() >= 1) chk("t6_p0", pop_log[0], RST_PC);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
